// File: rtl/rv32m_muldiv_seq.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and
// restoring divide on operand magnitudes, with a sign-fix cycle at the end.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | ready for a new op; RESULT keeps the last value
// CALC  | XLEN iteration cycles, then one sign-fix cycle
// DONE  | RESULT valid and held until the consumer takes it
module rv32m_muldiv_seq #(
    parameter int unsigned XLEN      = 32,
    parameter bit          EARLY_OUT = 1'b1
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            valid_in_i,
    output logic            ready_out_o,
    input  logic [XLEN-1:0] opa_i,
    input  logic [XLEN-1:0] opb_i,
    input  logic [2:0]      funct3_i,
    input  logic            flush_i,
    output logic            valid_out_o,
    input  logic            ready_in_i,
    output logic [XLEN-1:0] result_o,
    output logic            busy_o
);

    localparam int unsigned CW = $clog2(XLEN + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   b_q, b_d;
    logic [2:0]        op_q, op_d;
    logic              neg_q, neg_d;
    logic              special_q, special_d;
    logic [XLEN-1:0]   spec_res_q, spec_res_d;
    logic [XLEN-1:0]   result_q, result_d;

    logic              a_signed, b_signed, sgn_a, sgn_b;
    logic              div_zero, div_ovf, special, neg_acc;
    logic [XLEN-1:0]   abs_a, abs_b, spec_res;
    logic [XLEN-1:0]   hi, lo;
    logic [XLEN:0]     mul_sum, div_shift, div_diff;
    logic [2*XLEN-1:0] mul_next, div_next, prod_s;
    logic [XLEN-1:0]   quo_s, rem_s, fix_res;

    // Which operands are treated as two's complement for the requested op.
    always_comb begin
        a_signed = 1'b0;
        b_signed = 1'b0;
        case (funct3_i)
            3'b000, 3'b001, 3'b100, 3'b110: begin
                a_signed = 1'b1;
                b_signed = 1'b1;
            end
            3'b010:  a_signed = 1'b1;
            default: ;
        endcase
    end

    assign sgn_a = a_signed & opa_i[XLEN-1];
    assign sgn_b = b_signed & opb_i[XLEN-1];
    assign abs_a = sgn_a ? -opa_i : opa_i;
    assign abs_b = sgn_b ? -opb_i : opb_i;

    // Remainder follows the dividend; products and quotients follow sA^sB.
    assign neg_acc  = (funct3_i[2] & funct3_i[1]) ? sgn_a : (sgn_a ^ sgn_b);

    assign div_zero = funct3_i[2] & (opb_i == '0);
    assign div_ovf  = funct3_i[2] & ~funct3_i[0]
                    & (opa_i == {1'b1, {(XLEN-1){1'b0}}}) & (opb_i == '1);
    assign special  = div_zero | div_ovf;
    assign spec_res = div_zero ? (funct3_i[1] ? opa_i : '1)
                               : (funct3_i[1] ? '0 : opa_i);

    // acc holds {product_hi, multiplier} for multiply and {remainder, quotient} for divide.
    assign hi        = acc_q[2*XLEN-1:XLEN];
    assign lo        = acc_q[XLEN-1:0];
    assign mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, b_q} : '0);
    assign mul_next  = {mul_sum, lo[XLEN-1:1]};
    assign div_shift = {hi, lo[XLEN-1]};
    assign div_diff  = div_shift - {1'b0, b_q};
    assign div_next  = div_diff[XLEN] ? {div_shift[XLEN-1:0], lo[XLEN-2:0], 1'b0}
                                      : {div_diff[XLEN-1:0],  lo[XLEN-2:0], 1'b1};

    assign prod_s = neg_q ? -acc_q : acc_q;
    assign quo_s  = neg_q ? -lo : lo;
    assign rem_s  = neg_q ? -hi : hi;

    // Final result selection on the sign-fix cycle.
    always_comb begin
        if (special_q)
            fix_res = spec_res_q;
        else if (op_q[2])
            fix_res = op_q[1] ? rem_s : quo_s;
        else if (op_q[1:0] == 2'b00)
            fix_res = prod_s[XLEN-1:0];
        else
            fix_res = prod_s[2*XLEN-1:XLEN];
    end

    // Next-state, datapath update and capture; flush overrides everything.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        b_d        = b_q;
        op_d       = op_q;
        neg_d      = neg_q;
        special_d  = special_q;
        spec_res_d = spec_res_q;
        result_d   = result_q;
        if (flush_i) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (valid_in_i) begin
                        op_d       = funct3_i;
                        neg_d      = neg_acc;
                        b_d        = abs_b;
                        acc_d      = {{XLEN{1'b0}}, abs_a};
                        cnt_d      = CW'(XLEN);
                        special_d  = special;
                        spec_res_d = spec_res;
                        if (EARLY_OUT && special) begin
                            result_d = spec_res;
                            state_d  = S_DONE;
                        end else begin
                            state_d  = S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    if (cnt_q != '0) begin
                        acc_d = op_q[2] ? div_next : mul_next;
                        cnt_d = cnt_q - CW'(1);
                    end else begin
                        result_d = fix_res;
                        state_d  = S_DONE;
                    end
                end
                S_DONE: begin
                    if (ready_in_i)
                        state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            b_q        <= '0;
            op_q       <= '0;
            neg_q      <= 1'b0;
            special_q  <= 1'b0;
            spec_res_q <= '0;
            result_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            b_q        <= b_d;
            op_q       <= op_d;
            neg_q      <= neg_d;
            special_q  <= special_d;
            spec_res_q <= spec_res_d;
            result_q   <= result_d;
        end
    end

    assign ready_out_o = (state_q == S_IDLE);
    assign valid_out_o = (state_q == S_DONE);
    assign busy_o      = (state_q != S_IDLE);
    assign result_o    = result_q;

endmodule

// File: tb/tb_rv32m_muldiv_seq.sv
// Scoreboard bench for rv32m_muldiv_seq (XLEN=32, EARLY_OUT=1).
// Latency is counted in rising edges after the accepting edge: 33 for the
// iterative path, 0 for early-out ops (valid right after the accepting edge).
module tb_rv32m_muldiv_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid_in = 1'b0;
    logic        ready_out;
    logic [31:0] opa = '0;
    logic [31:0] opb = '0;
    logic [2:0]  funct3 = '0;
    logic        flush = 1'b0;
    logic        valid_out;
    logic        ready_in = 1'b0;
    logic [31:0] result;
    logic        busy;

    rv32m_muldiv_seq #(.XLEN(32), .EARLY_OUT(1'b1)) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .valid_in_i  (valid_in),
        .ready_out_o (ready_out),
        .opa_i       (opa),
        .opb_i       (opb),
        .funct3_i    (funct3),
        .flush_i     (flush),
        .valid_out_o (valid_out),
        .ready_in_i  (ready_in),
        .result_o    (result),
        .busy_o      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        int          lat;
        int          acc;
    } exp_t;

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
    } vec_t;

    exp_t        sb[$];
    exp_t        e;
    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    bit          vo_prev = 1'b0;
    logic [31:0] held = '0;
    int          bp_mode = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        vectors++;
        if (act !== exp_v) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp_v, $time);
        end
    endfunction

    function automatic logic [31:0] ref_res(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sbv;
        longint unsigned ua, ub;
        logic [63:0]     p;
        logic [31:0]     r;
        logic            ovf;
        sa  = $signed(a);
        sbv = $signed(b);
        ua  = {32'h0, a};
        ub  = {32'h0, b};
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        p   = '0;
        r   = '0;
        case (f)
            3'd0: begin p = sa * sbv; r = p[31:0]; end
            3'd1: begin p = sa * sbv; r = p[63:32]; end
            3'd2: begin p = sa * $signed(ub); r = p[63:32]; end
            3'd3: begin p = ua * ub; r = p[63:32]; end
            3'd4: begin
                if (b == 0) r = 32'hFFFF_FFFF;
                else if (ovf) r = a;
                else begin p = sa / sbv; r = p[31:0]; end
            end
            3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) r = a;
                else if (ovf) r = 32'h0;
                else begin p = sa % sbv; r = p[31:0]; end
            end
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    function automatic bit is_special(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        return f[2] && ((b == 0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    endfunction

    // Consumer: random READY_IN unless a directed test pins it.
    always @(negedge clk) begin
        if (bp_mode == 0) ready_in = ($urandom_range(0, 3) != 0);
        else              ready_in = (bp_mode == 2);
    end

    // Monitor: pop one expectation per VALID_OUT rise, check hold while waiting.
    always @(negedge clk) begin
        if (!rst_n) begin
            vo_prev = 1'b0;
        end else begin
            if (valid_out) begin
                chk("done_handshake{ready_out,busy}", {30'h0, ready_out, busy}, 32'h1);
                if (!vo_prev) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_result_valid", 32'h1, 32'h0);
                    end else begin
                        e = sb.pop_front();
                        chk("result", result, e.res);
                        chk("latency_edges", cyc - e.acc, e.lat);
                    end
                    held = result;
                end else begin
                    chk("result_stable", result, held);
                end
            end
            vo_prev = valid_out;
        end
    end

    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input bit track);
        int n;
        exp_t x;
        n = 0;
        @(negedge clk);
        while (!ready_out && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) begin
            chk("accept_timeout", 32'h1, 32'h0);
            return;
        end
        valid_in = 1'b1;
        funct3   = f;
        opa      = a;
        opb      = b;
        if (track) begin
            x.res = ref_res(f, a, b);
            x.lat = is_special(f, a, b) ? 0 : 33;
            x.acc = cyc + 1;
            sb.push_back(x);
        end
        @(negedge clk);
        valid_in = 1'b0;
        funct3   = 3'($urandom_range(0, 7));
        opa      = $urandom;
        opb      = $urandom;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || busy) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) chk("drain_timeout", 32'h1, 32'h0);
    endtask

    vec_t dir[12];

    initial begin
        logic [2:0]  f;
        logic [31:0] a, b;
        int          n;

        dir[0]  = '{3'b000, 32'd7,          32'hFFFF_FFFD};
        dir[1]  = '{3'b001, 32'h8000_0000,  32'h8000_0000};
        dir[2]  = '{3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF};
        dir[3]  = '{3'b010, 32'hFFFF_FFFF,  32'hFFFF_FFFF};
        dir[4]  = '{3'b100, 32'hFFFF_FFF9,  32'd2};
        dir[5]  = '{3'b110, 32'hFFFF_FFF9,  32'd2};
        dir[6]  = '{3'b101, 32'd100,        32'd7};
        dir[7]  = '{3'b111, 32'd100,        32'd7};
        dir[8]  = '{3'b100, 32'd5,          32'd0};
        dir[9]  = '{3'b110, 32'd5,          32'd0};
        dir[10] = '{3'b100, 32'h8000_0000,  32'hFFFF_FFFF};
        dir[11] = '{3'b110, 32'h8000_0000,  32'hFFFF_FFFF};

        #2;
        chk("reset_result", result, 32'h0);
        chk("reset_valid_out", {31'h0, valid_out}, 32'h0);
        chk("reset_busy", {31'h0, busy}, 32'h0);
        chk("reset_ready_out", {31'h0, ready_out}, 32'h1);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (dir[i]) issue(dir[i].f, dir[i].a, dir[i].b, 1'b1);

        for (int k = 0; k < 200; k++) begin
            f = 3'($urandom_range(0, 7));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 9))
                0: b = 32'h0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: a = $urandom_range(0, 255);
                3: b = $urandom_range(1, 15);
                4: b = -($urandom_range(1, 15));
                default: ;
            endcase
            issue(f, a, b, 1'b1);
        end
        wait_drain();

        // Backpressure: result held in DONE, new requests refused.
        bp_mode  = 1;
        ready_in = 1'b0;
        issue(3'b101, 32'd100, 32'd7, 1'b1);
        n = 0;
        while (!valid_out && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("bp_valid_timeout", 32'h1, 32'h0);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            valid_in = ~valid_in;
            funct3   = 3'b000;
            opa      = $urandom;
            opb      = $urandom;
        end
        valid_in = 1'b0;
        bp_mode  = 2;
        ready_in = 1'b1;
        @(negedge clk);
        chk("bp_release_valid_out", {31'h0, valid_out}, 32'h0);
        chk("bp_release_ready_out", {31'h0, ready_out}, 32'h1);
        bp_mode = 0;
        wait_drain();

        // Flush coinciding with a request: nothing is accepted.
        @(negedge clk);
        valid_in = 1'b1;
        flush    = 1'b1;
        funct3   = 3'b000;
        opa      = 32'd3;
        opb      = 32'd4;
        @(negedge clk);
        valid_in = 1'b0;
        flush    = 1'b0;
        chk("flush_beats_accept_busy", {31'h0, busy}, 32'h0);

        // Flush on the 10th edge of a divide.
        issue(3'b100, 32'h1234_5678, 32'd3, 1'b0);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_busy", {31'h0, busy}, 32'h0);
        chk("flush_ready_out", {31'h0, ready_out}, 32'h1);
        repeat (40) @(negedge clk);
        issue(3'b101, 32'd100, 32'd7, 1'b1);
        wait_drain();

        // Asynchronous reset in the middle of a multiply.
        issue(3'b000, 32'h0001_2345, 32'h0000_6789, 1'b0);
        repeat (5) @(negedge clk);
        chk("pre_reset_busy", {31'h0, busy}, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_result", result, 32'h0);
        chk("async_reset_busy", {31'h0, busy}, 32'h0);
        chk("async_reset_valid_out", {31'h0, valid_out}, 32'h0);
        chk("async_reset_ready_out", {31'h0, ready_out}, 32'h1);
        @(negedge clk);
        rst_n = 1'b1;
        issue(3'b001, 32'hDEAD_BEEF, 32'h1357_9BDF, 1'b1);
        wait_drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
